jtframe_paddle_arb: RTL and testbench

Two-player paddle controller: latches mouse delta packets from two independent mouse ports, arbitrates them round-robin onto one shared scale/add/clamp datapath, and maintains one 8-bit paddle position per player. Sits between the mouse/PS2 decoding and the core's input mux. Replaces two free-running per-player accumulators with one sequenced datapath. Packets arriving while a player is already pending are merged rather than dropped.

---
 rtl/jtframe_paddle_arb.sv | 159 +++++++++++++++
 tb/tb_jtframe_paddle_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_paddle_arb.sv
// rtl/jtframe_paddle_arb.sv - two-player paddle arbiter with one shared scale/add/clamp datapath
//
// Latches mouse delta packets from two ports. Each player has a pending flag and an
// 11-bit saturating accumulator, so packets that arrive while the player waits are merged.
// A round-robin arbiter sequences the pending players through IDLE -> SCALE -> SUM, and
// the granted paddle register is written in SUM.
//
// Optional feature macro: JTFRAME_PADDLE_ACCEL_EN. When it is defined, operands with
// |op| >= ACCEL_TH are doubled in SCALE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   en                    paddle mode enable; when low, strobes are ignored and pending is cleared
//   mouse_dx1, mouse_st1  player 1 signed delta and one-cycle strobe
//   mouse_dx2, mouse_st2  player 2 signed delta and one-cycle strobe
//   paddle1, paddle2      paddle positions, clamped to [0, MAX]
//   upd                   one-cycle pulse per player when its paddle is written
//   busy                  FSM not IDLE
module jtframe_paddle_arb #(
  parameter logic [7:0] MAX      = 8'hFF,
  parameter int         SENS     = 0,
  parameter int         ACCEL_TH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic signed [8:0] mouse_dx1,
  input  logic              mouse_st1,
  input  logic signed [8:0] mouse_dx2,
  input  logic              mouse_st2,
  output logic [7:0]        paddle1,
  output logic [7:0]        paddle2,
  output logic [1:0]        upd,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCALE = 2'd1;
  localparam logic [1:0] ST_SUM   = 2'd2;

  logic [1:0]         state;
  logic [1:0]         pend;
  logic signed [10:0] acc [2];
  logic               ptr;      // last served player id
  logic               gid;      // player currently in flight
  logic signed [10:0] op;
  logic signed [11:0] op_x;
  logic signed [11:0] delta;
  logic [1:0]         st_in;
  logic signed [8:0]  dx_in [2];
  logic               grant;
  logic               grant_id;
  logic [7:0]         psel;
  logic signed [12:0] sum;
  logic [7:0]         res;

  assign st_in    = {mouse_st2, mouse_st1};
  assign dx_in[0] = mouse_dx1;
  assign dx_in[1] = mouse_dx2;
  assign busy     = (state != ST_IDLE);

  // On a tie the player that was not served last wins.
  assign grant    = (state == ST_IDLE) && en && (pend != 2'b00);
  assign grant_id = (pend == 2'b11) ? ~ptr : pend[1];

  function automatic logic signed [10:0] sat_add(input logic signed [10:0] a,
                                                 input logic signed [8:0]  d);
    logic signed [11:0] s;
    s = $signed({a[10], a}) + $signed({{3{d[8]}}, d});
    if (s > 12'sd1023)       sat_add = 11'sd1023;
    else if (s < -12'sd1024) sat_add = 11'b100_0000_0000;
    else                     sat_add = s[10:0];
  endfunction

  // A strobe on the same edge as its player's grant restarts the accumulator:
  // the old value has just been handed to the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= 2'b00;
      acc[0] <= '0;
      acc[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!en) begin
          pend[i] <= 1'b0;
        end else if (st_in[i]) begin
          if (pend[i] && !(grant && grant_id == 1'(i)))
            acc[i] <= sat_add(acc[i], dx_in[i]);
          else
            acc[i] <= {{2{dx_in[i][8]}}, dx_in[i]};
          pend[i] <= 1'b1;
        end else if (grant && grant_id == 1'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

`ifdef JTFRAME_PADDLE_ACCEL_EN
  logic [10:0] op_abs;
  assign op_abs = op[10] ? $unsigned(-op) : $unsigned(op);
  assign op_x   = ({1'b0, op_abs} >= 12'(ACCEL_TH)) ? {op, 1'b0} : {op[10], op};
`else
  logic unused_accel_th;
  assign unused_accel_th = ^ACCEL_TH;
  assign op_x            = {op[10], op};
`endif

  // Paddle is zero-extended; 13 bits hold any paddle + delta without wrapping.
  assign psel = gid ? paddle2 : paddle1;
  assign sum  = $signed({5'b0, psel}) + $signed({delta[11], delta});

  always_comb begin
    res = sum[7:0];
    if (sum[12])                          res = 8'd0;
    else if (sum > $signed({5'b0, MAX})) res = MAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= 1'b1;
      gid     <= 1'b0;
      op      <= '0;
      delta   <= '0;
      paddle1 <= 8'd0;
      paddle2 <= 8'd0;
      upd     <= 2'b00;
    end else begin
      upd <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            gid   <= grant_id;
            op    <= acc[grant_id];
            ptr   <= grant_id;
            state <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          delta <= op_x >>> SENS;   // arithmetic shift, rounds toward -inf
          state <= ST_SUM;
        end
        ST_SUM: begin
          if (gid) begin
            paddle2 <= res;
            upd     <= 2'b10;
          end else begin
            paddle1 <= res;
            upd     <= 2'b01;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_paddle_arb.sv
// tb/tb_jtframe_paddle_arb.sv - scoreboard bench for jtframe_paddle_arb, three parameter sets
module tb_jtframe_paddle_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic signed [8:0] dx1 = '0;
  logic signed [8:0] dx2 = '0;
  logic st1 = 1'b0;
  logic st2 = 1'b0;

  logic [7:0] p1_o [3];
  logic [7:0] p2_o [3];
  logic [1:0] upd_o [3];
  logic       busy_o [3];

  always #5 clk = ~clk;

  // instance 0: MAX=FF SENS=0, instance 1: MAX=200 SENS=0, instance 2: MAX=FF SENS=2
  jtframe_paddle_arb #(.MAX(8'hFF), .SENS(0), .ACCEL_TH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mouse_dx1(dx1), .mouse_st1(st1),
    .mouse_dx2(dx2), .mouse_st2(st2), .paddle1(p1_o[0]), .paddle2(p2_o[0]),
    .upd(upd_o[0]), .busy(busy_o[0]));
  jtframe_paddle_arb #(.MAX(8'd200), .SENS(0), .ACCEL_TH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mouse_dx1(dx1), .mouse_st1(st1),
    .mouse_dx2(dx2), .mouse_st2(st2), .paddle1(p1_o[1]), .paddle2(p2_o[1]),
    .upd(upd_o[1]), .busy(busy_o[1]));
  jtframe_paddle_arb #(.MAX(8'hFF), .SENS(2), .ACCEL_TH(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mouse_dx1(dx1), .mouse_st1(st1),
    .mouse_dx2(dx2), .mouse_st2(st2), .paddle1(p1_o[2]), .paddle2(p2_o[2]),
    .upd(upd_o[2]), .busy(busy_o[2]));

  typedef struct {
    int id;
    int val;
    int cyc;
  } exp_t;

  int   p_max  [3] = '{255, 200, 255};
  int   p_sens [3] = '{0, 0, 2};
  int   m_pend [3][2];
  int   m_acc  [3][2];
  int   m_pad  [3][2];
  int   m_ptr  [3];
  int   m_wr   [3];
  exp_t q [3][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

`ifdef JTFRAME_PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic reset_model(input int k);
    for (int p = 0; p < 2; p++) begin
      m_pend[k][p] = 0;
      m_acc[k][p]  = 0;
      m_pad[k][p]  = 0;
    end
    m_ptr[k] = 1;
    m_wr[k]  = -10;
    q[k].delete();
  endtask

  // Resulting paddle value from the datapath rules: optional doubling, floor division, clamp.
  function automatic int apply_rule(input int k, input int pad, input int acc_v);
    int op, d, delta, r;
    op = acc_v;
    if (ACCEL && (op >= 16 || op <= -16)) op = op * 2;
    d = 1 << p_sens[k];
    if (op >= 0) delta = op / d;
    else         delta = -((-op + d - 1) / d);
    r = pad + delta;
    if (r < 0) r = 0;
    if (r > p_max[k]) r = p_max[k];
    return r;
  endfunction

  // Called once per rising edge with the inputs that edge samples.
  task automatic model_step();
    int st[2];
    int dx[2];
    int g, r, s;
    exp_t e;
    cyc++;
    st[0] = int'(st1);
    st[1] = int'(st2);
    dx[0] = int'(dx1);
    dx[1] = int'(dx2);
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        reset_model(k);
        continue;
      end
      // previous write finished before this edge, so a new grant can start
      if (cyc > m_wr[k] && en && (m_pend[k][0] != 0 || m_pend[k][1] != 0)) begin
        if (m_pend[k][0] != 0 && m_pend[k][1] != 0) g = 1 - m_ptr[k];
        else if (m_pend[k][0] != 0)                 g = 0;
        else                                        g = 1;
        m_pend[k][g] = 0;
        m_ptr[k] = g;
        r = apply_rule(k, m_pad[k][g], m_acc[k][g]);
        m_pad[k][g] = r;
        e.id = g;
        e.val = r;
        e.cyc = cyc + 2;
        q[k].push_back(e);
        m_wr[k] = cyc + 2;
      end
      for (int p = 0; p < 2; p++) begin
        if (!en) begin
          m_pend[k][p] = 0;
        end else if (st[p] != 0) begin
          if (m_pend[k][p] != 0) begin
            s = m_acc[k][p] + dx[p];
            if (s > 1023)  s = 1023;
            if (s < -1024) s = -1024;
            m_acc[k][p] = s;
          end else begin
            m_acc[k][p] = dx[p];
          end
          m_pend[k][p] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    repeat (8) tick();
  endtask

  task automatic do_reset();
    st1 = 1'b0;
    st2 = 1'b0;
    en = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic strobe1(input int v);
    dx1 = v[8:0];
    st1 = 1'b1;
    tick();
    st1 = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a DUT signals a write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("busy[%0d]", k), int'(busy_o[k]), (cyc < m_wr[k]) ? 1 : 0);
          if (upd_o[k] != 2'b00) begin
            if (q[k].size() == 0) begin
              chk($sformatf("unexpected_upd[%0d]", k), int'(upd_o[k]), 0);
            end else begin
              e = q[k].pop_front();
              chk($sformatf("upd_mask[%0d]", k), int'(upd_o[k]), (e.id == 0) ? 1 : 2);
              chk($sformatf("upd_cycle[%0d]", k), cyc, e.cyc);
              chk($sformatf("paddle%0d[%0d]", e.id + 1, k),
                  (e.id == 0) ? int'(p1_o[k]) : int'(p2_o[k]), e.val);
            end
          end else if (q[k].size() != 0 && q[k][0].cyc < cyc) begin
            e = q[k].pop_front();
            chk($sformatf("missing_write[%0d]", k), cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    int v;
    for (int k = 0; k < 3; k++) reset_model(k);
    tick();
    tick();
    // reset state
    chk("rst_paddle1", int'(p1_o[0]), 0);
    chk("rst_paddle2", int'(p2_o[0]), 0);
    chk("rst_upd", int'(upd_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    rst_n = 1'b1;
    tick();

    // single strobe: written exactly three edges later, one-cycle upd
    strobe1(20);
    tick();
    tick();
    chk("lat_before", int'(p1_o[0]), 0);
    tick();
    chk("lat_paddle1", int'(p1_o[0]), 20);
    chk("lat_upd", int'(upd_o[0]), 1);
    chk("lat_paddle2", int'(p2_o[0]), 0);
    tick();
    chk("lat_upd_off", int'(upd_o[0]), 0);
    drain();

    // simultaneous strobes, twice: player 1 first both times
    do_reset();
    for (int rep = 1; rep <= 2; rep++) begin
      dx1 = 9'sd5;
      dx2 = 9'sd7;
      st1 = 1'b1;
      st2 = 1'b1;
      tick();
      st1 = 1'b0;
      st2 = 1'b0;
      repeat (3) tick();
      chk($sformatf("tie%0d_p1", rep), int'(p1_o[0]), 5 * rep);
      chk($sformatf("tie%0d_p2_wait", rep), int'(p2_o[0]), 7 * (rep - 1));
      repeat (3) tick();
      chk($sformatf("tie%0d_p2", rep), int'(p2_o[0]), 7 * rep);
    end
    drain();

    // clamps
    do_reset();
    strobe1(250);
    drain();
    chk("clamp_250", int'(p1_o[0]), 250);
    chk("clamp_max200", int'(p1_o[1]), 200);
    strobe1(20);
    drain();
    chk("clamp_255", int'(p1_o[0]), 255);
    // zero-delta P2 write keeps the FSM busy while two P1 packets merge into -300
    dx2 = 9'sd0;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    strobe1(-150);
    strobe1(-150);
    drain();
    chk("clamp_0", int'(p1_o[0]), 0);
    chk("zero_delta_p2", int'(p2_o[0]), 0);

    // merging while busy
    do_reset();
    strobe1(1);
    dx2 = 9'sd3;
    st2 = 1'b1;
    tick();
    dx2 = 9'sd4;
    tick();
    dx2 = 9'sd5;
    tick();
    st2 = 1'b0;
    drain();
    chk("merge_p2", int'(p2_o[0]), 12);
    chk("merge_p1", int'(p1_o[0]), 1);

    // sensitivity shift rounds toward -inf
    do_reset();
    strobe1(40);
    drain();
    chk("sens_10", int'(p1_o[2]), 10);
    strobe1(-1);
    drain();
    chk("sens_9", int'(p1_o[2]), 9);
    chk("sens0_39", int'(p1_o[0]), 39);

    // acceleration threshold
    do_reset();
    strobe1(16);
    drain();
    chk("accel_16", int'(p1_o[0]), ACCEL ? 32 : 16);
    strobe1(15);
    drain();
    chk("accel_15", int'(p1_o[0]), ACCEL ? 47 : 31);

    // en low drops pending requests but lets the update in flight finish
    do_reset();
    strobe1(2);
    dx2 = 9'sd9;
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    en = 1'b0;
    tick();
    strobe1(50);
    repeat (3) tick();
    en = 1'b1;
    drain();
    chk("en_p1", int'(p1_o[0]), 2);
    chk("en_p2", int'(p2_o[0]), 0);

    // reset during SUM
    strobe1(30);
    drain();
    chk("pre_rst_p1", int'(p1_o[0]), 32);
    strobe1(50);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_p1", int'(p1_o[0]), 0);
    chk("midrst_upd", int'(upd_o[0]), 0);
    chk("midrst_busy", int'(busy_o[0]), 0);
    tick();
    rst_n = 1'b1;
    drain();
    chk("postrst_p1", int'(p1_o[0]), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      en = ($urandom_range(0, 15) != 0);
      st1 = ($urandom_range(0, 3) == 0);
      st2 = ($urandom_range(0, 3) == 0);
      v = int'($urandom_range(0, 511));
      if (v > 255) v -= 512;
      dx1 = v[8:0];
      v = int'($urandom_range(0, 511));
      if (v > 255) v -= 512;
      dx2 = v[8:0];
      tick();
    end
    st1 = 1'b0;
    st2 = 1'b0;
    en = 1'b1;
    drain();
    drain();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("final_p1[%0d]", k), int'(p1_o[k]), m_pad[k][0]);
      chk($sformatf("final_p2[%0d]", k), int'(p2_o[k]), m_pad[k][1]);
      chk($sformatf("queue_empty[%0d]", k), q[k].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
